lc3_ea_ctrl: RTL

Multi-cycle effective-address controller for the LC-3 datapath. It decodes the instruction register, selects and sign-extends the correct offset field with parameterised `sext` instances, and adds the result to PC or BaseR. For LDI/STI it also sequences the indirect memory read that produces the final address. It sits between the IR/PC/register file and the MAR/PC-load logic and is started by the main control FSM.

---
 rtl/lc3_ea_ctrl_pkg.sv | 31 +++
 rtl/lc3_ea_ctrl_sext.sv | 10 +
 rtl/lc3_ea_ctrl.sv | 76 +++++++
 3 files changed

// File: rtl/lc3_ea_ctrl_pkg.sv
// lc3_ea_ctrl_pkg: opcodes, state/field-select encodings and the opcode decoder for lc3_ea_ctrl.
package lc3_ea_ctrl_pkg;
  localparam logic [3:0] OP_BR  = 4'h0;
  localparam logic [3:0] OP_LD  = 4'h2;
  localparam logic [3:0] OP_ST  = 4'h3;
  localparam logic [3:0] OP_JSR = 4'h4;
  localparam logic [3:0] OP_LDR = 4'h6;
  localparam logic [3:0] OP_STR = 4'h7;
  localparam logic [3:0] OP_LDI = 4'hA;
  localparam logic [3:0] OP_STI = 4'hB;
  localparam logic [3:0] OP_JMP = 4'hC;
  localparam logic [3:0] OP_LEA = 4'hE;
  typedef enum logic [2:0] {S_IDLE, S_DECODE, S_ADD, S_IND, S_DONE} state_t;
  typedef enum logic [1:0] {SEL_ZERO, SEL_OFF6, SEL_OFF9, SEL_OFF11} sel_t;
  typedef struct packed {
    sel_t sel;
    logic use_pc;
    logic ind;
    logic illegal;
  } dec_t;
  function automatic dec_t decode(input logic [3:0] op, input logic jsr);
    case (op)
      OP_BR, OP_LD, OP_ST, OP_LEA: decode = '{SEL_OFF9, 1'b1, 1'b0, 1'b0};
      OP_LDI, OP_STI:              decode = '{SEL_OFF9, 1'b1, 1'b1, 1'b0};
      OP_JSR:                      decode = jsr ? '{SEL_OFF11, 1'b1, 1'b0, 1'b0} : '{SEL_ZERO, 1'b0, 1'b0, 1'b0};
      OP_JMP:                      decode = '{SEL_ZERO, 1'b0, 1'b0, 1'b0};
      OP_LDR, OP_STR:              decode = '{SEL_OFF6, 1'b0, 1'b0, 1'b0};
      default:                     decode = '{SEL_ZERO, 1'b0, 1'b0, 1'b1};
    endcase
  endfunction
endpackage

// File: rtl/lc3_ea_ctrl_sext.sv
// sext: sign-extend an N-bit field to WIDTH bits.
module sext #(
  parameter int N     = 6,
  parameter int WIDTH = 16
) (
  input  logic [N-1:0]     x,
  output logic [WIDTH-1:0] y
);
  assign y = {{(WIDTH-N){x[N-1]}}, x};
endmodule

// File: rtl/lc3_ea_ctrl.sv
// lc3_ea_ctrl: multi-cycle LC-3 effective-address unit with LDI/STI indirect read sequencing.
module lc3_ea_ctrl
  import lc3_ea_ctrl_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] ir,
  input  logic [WIDTH-1:0] pc,
  output logic [2:0]       sr_addr,
  input  logic [WIDTH-1:0] sr_data,
  output logic             mem_req,
  output logic [WIDTH-1:0] mem_addr,
  input  logic             mem_rdy,
  input  logic [WIDTH-1:0] mem_rdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] ea,
  output logic             illegal
);
  state_t state, next;
  dec_t dec_q;
  logic [WIDTH-1:0] ir_q, pc_q, base_q, addr_q, ea_q;
  logic [WIDTH-1:0] off6, off9, off11, off, sum;
  sext #(.N(6),  .WIDTH(WIDTH)) u_off6  (.x(ir_q[5:0]),  .y(off6));
  sext #(.N(9),  .WIDTH(WIDTH)) u_off9  (.x(ir_q[8:0]),  .y(off9));
  sext #(.N(11), .WIDTH(WIDTH)) u_off11 (.x(ir_q[10:0]), .y(off11));
  always_comb
    off = dec_q.sel == SEL_OFF6  ? off6  :
          dec_q.sel == SEL_OFF9  ? off9  :
          dec_q.sel == SEL_OFF11 ? off11 : '0;
  assign sum = (dec_q.use_pc ? pc_q : base_q) + off;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= S_IDLE;
    else     state <= next;
  always_comb
    next = state == S_IDLE   ? (start ? S_DECODE : S_IDLE) :
           state == S_DECODE ? S_ADD :
           state == S_ADD    ? (dec_q.ind ? S_IND : S_DONE) :
           state == S_IND    ? (mem_rdy ? S_DONE : S_IND) : S_IDLE;
  always_comb begin
    busy     = state != S_IDLE;
    done     = state == S_DONE;
    mem_req  = state == S_IND;
    mem_addr = mem_req ? addr_q : '0;
    sr_addr  = state == S_DECODE ? ir_q[8:6] : 3'd0;
  end
  // ea_q holds its value from DONE until the next accepted start
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      ir_q   <= '0;
      pc_q   <= '0;
      base_q <= '0;
      addr_q <= '0;
      ea_q   <= '0;
      dec_q  <= '0;
    end else begin
      if (state == S_IDLE && start) begin
        ir_q <= ir;
        pc_q <= pc;
      end
      if (state == S_DECODE) begin
        base_q <= sr_data;
        dec_q  <= decode(ir_q[15:12], ir_q[11]);
      end
      if (state == S_ADD) begin
        addr_q <= sum;
        ea_q   <= dec_q.illegal ? '0 : sum;
      end
      if (state == S_IND && mem_rdy) ea_q <= mem_rdata;
    end
  assign ea      = ea_q;
  assign illegal = dec_q.illegal;
endmodule
